// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: per-master pending slots, round-robin issue of one
// transaction at a time to a shared slave, with a bounded ISSUE+WAIT timeout.

module wb_arb_slot #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            cyc,
  input  logic            stb,
  input  logic            busy,
  input  logic            take,
  input  logic            we,
  input  logic [DW/8-1:0] sel,
  input  logic [AW-1:0]   adr,
  input  logic [DW-1:0]   dat,
  output logic            vld,
  output logic            q_we,
  output logic [DW/8-1:0] q_sel,
  output logic [AW-1:0]   q_adr,
  output logic [DW-1:0]   q_dat
);
  // Strobes that hit a full slot or an in-flight master are dropped silently.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld   <= 1'b0;
      q_we  <= 1'b0;
      q_sel <= '0;
      q_adr <= '0;
      q_dat <= '0;
    end else if (take || !cyc) begin
      vld <= 1'b0;
    end else if (stb && !vld && !busy) begin
      vld   <= 1'b1;
      q_we  <= we;
      q_sel <= sel;
      q_adr <= adr;
      q_dat <= dat;
    end
  end
endmodule

module wb_arbiter2 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_stall_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]           m_cyc, m_stb, m_we;
  logic [1:0][DW/8-1:0] m_sel;
  logic [1:0][AW-1:0]   m_adr;
  logic [1:0][DW-1:0]   m_dat;
  logic [1:0]           slot_v, slot_we, take, busy;
  logic [1:0][DW/8-1:0] slot_sel;
  logic [1:0][AW-1:0]   slot_adr;
  logic [1:0][DW-1:0]   slot_dat;
  logic [1:0]           ack_q, err_q;
  logic [1:0][DW-1:0]   rdat_q;

  logic [1:0]    state;
  logic          last, dropped, pick, own, issue, rsp, to_hit, done, done_err, deliver;
  logic [CW-1:0] cnt;

  assign m_cyc = {m1_cyc_i, m0_cyc_i};
  assign m_stb = {m1_stb_i, m0_stb_i};
  assign m_we  = {m1_we_i,  m0_we_i};
  assign m_sel = {m1_sel_i, m0_sel_i};
  assign m_adr = {m1_adr_i, m0_adr_i};
  assign m_dat = {m1_dat_i, m0_dat_i};

  assign m0_ack_o = ack_q[0];
  assign m1_ack_o = ack_q[1];
  assign m0_err_o = err_q[0];
  assign m1_err_o = err_q[1];
  assign m0_dat_o = rdat_q[0];
  assign m1_dat_o = rdat_q[1];

  for (genvar i = 0; i < 2; i++) begin : g_slot
    assign busy[i] = (state != S_IDLE) && grant_o[i];
    assign take[i] = issue && (pick == 1'(i));
    wb_arb_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk_i (clk_i),
      .rstn_i(rstn_i),
      .cyc   (m_cyc[i]),
      .stb   (m_stb[i]),
      .busy  (busy[i]),
      .take  (take[i]),
      .we    (m_we[i]),
      .sel   (m_sel[i]),
      .adr   (m_adr[i]),
      .dat   (m_dat[i]),
      .vld   (slot_v[i]),
      .q_we  (slot_we[i]),
      .q_sel (slot_sel[i]),
      .q_adr (slot_adr[i]),
      .q_dat (slot_dat[i])
    );
  end

  // A tie goes to the master not granted last; a lone request wins outright.
  always_comb begin
    pick     = (slot_v == 2'b11) ? ~last : slot_v[1];
    issue    = (state == S_IDLE) && (|slot_v);
    own      = grant_o[1];
    rsp      = ((state == S_WAIT) || (state == S_ISSUE && !s_stall_i)) && (s_ack_i || s_err_i);
    to_hit   = (TIMEOUT != 0) && (state != S_IDLE) && (cnt == CW'(TIMEOUT - 1));
    done     = rsp || to_hit;
    done_err = rsp ? s_err_i : 1'b1;
    deliver  = done && !dropped && m_cyc[own];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= S_IDLE;
      s_cyc_o   <= 1'b0;
      s_stb_o   <= 1'b0;
      s_we_o    <= 1'b0;
      s_sel_o   <= '0;
      s_adr_o   <= '0;
      s_dat_o   <= '0;
      grant_o   <= 2'b00;
      timeout_o <= 1'b0;
      last      <= 1'b1;
      cnt       <= '0;
      dropped   <= 1'b0;
      ack_q     <= '0;
      err_q     <= '0;
      rdat_q    <= '0;
    end else begin
      ack_q     <= '0;
      err_q     <= '0;
      timeout_o <= 1'b0;
      if (issue) begin
        state   <= S_ISSUE;
        s_cyc_o <= 1'b1;
        s_stb_o <= 1'b1;
        s_we_o  <= slot_we[pick];
        s_sel_o <= slot_sel[pick];
        s_adr_o <= slot_adr[pick];
        s_dat_o <= slot_dat[pick];
        grant_o <= pick ? 2'b10 : 2'b01;
        last    <= pick;
        cnt     <= '0;
        dropped <= 1'b0;
      end else if (done) begin
        // A real slave response beats the timeout in the same cycle.
        state     <= S_IDLE;
        s_cyc_o   <= 1'b0;
        s_stb_o   <= 1'b0;
        grant_o   <= 2'b00;
        timeout_o <= ~rsp;
        if (deliver) begin
          if (done_err) begin
            err_q[own] <= 1'b1;
          end else begin
            ack_q[own]  <= 1'b1;
            rdat_q[own] <= s_dat_i;
          end
        end
      end else if (state != S_IDLE) begin
        cnt <= cnt + 1'b1;
        if (!m_cyc[own]) dropped <= 1'b1;
        if (state == S_ISSUE && !s_stall_i) begin
          state   <= S_WAIT;
          s_stb_o <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master Wishbone arbiter sharing the single `wishbone_bus_logic` slave (LEDs, DIP, buttons, ADAU audio registers) between the NEORV32 external bus (master 0) and the planned audio sample DMA (master 1). Each master's single-cycle strobe is latched into a per-master pending slot. One transaction at a time is issued to the slave under round-robin priority. A bus timeout returns an error instead of hanging either master.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width (multiple of 8)
- `TIMEOUT`, 255, cycles allowed in ISSUE+WAIT before abort; 0 disables
- `clk_i` in 1: single clock, rising edge
- `rstn_i` in 1: reset, asynchronous, active-low
- `m0_cyc_i` in 1: master 0 cycle valid
- `m0_stb_i` in 1: master 0 request strobe, one-cycle pulse
- `m0_we_i` in 1, `m0_sel_i` in DW/8, `m0_adr_i` in AW, `m0_dat_i` in DW: request fields, valid with stb
- `m0_dat_o` out DW: read data, valid with ack
- `m0_ack_o` out 1, `m0_err_o` out 1: completion pulses
- `m1_cyc_i` … `m1_err_o`: identical set for master 1
- `s_cyc_o` out 1, `s_stb_o` out 1, `s_we_o` out 1, `s_sel_o` out DW/8, `s_adr_o` out AW, `s_dat_o` out DW: slave request
- `s_dat_i` in DW, `s_ack_i` in 1, `s_err_i` in 1, `s_stall_i` in 1: slave response
- `grant_o` out 2: one-hot owner of the in-flight transaction, 00 when idle
- `timeout_o` out 1: one-cycle pulse on timeout abort

## Operation
- Per-master pending slot (valid bit + we/sel/adr/dat). It is loaded on any edge with `mX_cyc_i & mX_stb_i` when the slot is empty and master X is not in flight.
- A strobe while the master's slot is full or its transaction is in flight is a protocol violation. It is dropped, with no ack or err.
- `mX_cyc_i` low clears master X's pending slot if it has not been issued yet.
- FSM states:
  - IDLE: if any slot is valid, select one, copy its fields to the slave registers, clear the slot, go to ISSUE.
  - ISSUE: `s_cyc_o=s_stb_o=1`. When `s_stall_i=0`, go to WAIT.
  - WAIT: `s_cyc_o=1`, `s_stb_o=0`. On `s_ack_i` or `s_err_i`, go to IDLE.
- `s_ack_i`/`s_err_i` in ISSUE with stall low is accepted directly and the FSM goes to IDLE.
- Round-robin: a `last` bit records the most recently granted master. When both slots are valid, the other master wins. Reset value `last=1`, so master 0 wins the first tie.
- A single valid slot is granted immediately, regardless of `last`.
- Completion: `mX_ack_o` or `mX_err_o` pulses for the granted master, and `mX_dat_o <= s_dat_i` on ack. If the owner dropped cyc while in flight, the completion is discarded (no pulse).
- If ack and err arrive in the same cycle, err wins.
- Timeout: a counter is cleared on entering ISSUE and increments each cycle in ISSUE/WAIT. When it reaches `TIMEOUT`: force IDLE, deassert `s_cyc_o`, pulse `mX_err_o` and `timeout_o`. A slave response in the expiry cycle takes precedence over the timeout.
- Reset mid-transaction: all state clears immediately and pending slots are lost. Masters see neither ack nor err.

## Timing
- All outputs are registered. Reset values: all outputs 0, `grant_o=00`, FSM IDLE, both slots empty, counter 0.
- Strobe sampled at edge N: `s_stb_o` high after edge N+1 if the arbiter is idle.
- Slave ack sampled at edge M: `mX_ack_o` and `mX_dat_o` valid for exactly one cycle after edge M. The FSM is in IDLE after edge M and can issue a waiting request's `s_stb_o` after edge M+1.
- Zero-stall, single-cycle-ack slave: one transaction every 3 cycles. Stall extends ISSUE cycle-for-cycle.
- `grant_o` is set on entering ISSUE and cleared on entering IDLE.

## Test plan
- Single read, m0 strobe at adr 0x8000_0004, slave acks 1 cycle after stb with 0xA5 → `s_stb_o` high 1 cycle after strobe, m0 ack 1 cycle after slave ack, `m0_dat_o=0x000000A5`, `grant_o` 01 then 00.
- Same-cycle strobes from both masters, four back-to-back rounds → issue order m0,m1,m0,m1… and no request lost.
- `s_stall_i` held 4 cycles during ISSUE → `s_stb_o` high 5 cycles, one ack to the master.
- `TIMEOUT=8`, slave never responds → `s_cyc_o` low and `m1_err_o`+`timeout_o` pulse 8 cycles after entering ISSUE; the queued m0 request is issued next.
- `s_err_i` with `s_ack_i` → `m0_err_o` only. m1 drops cyc while pending → request never issued. m0 drops cyc while in flight → ack discarded.
- `rstn_i` low in WAIT → all outputs 0 asynchronously. After release, new m1 strobe served normally.
